// File: rtl/sfu_err_monitor_if.sv
// rtl/sfu_err_monitor_if.sv - golden and SFU-result valid/ready stream bundle
//
// Purpose: carries the two input streams of sfu_err_monitor.
//   gold_valid/gold_ready/gold_data : golden value stream
//   res_valid/res_ready/res_data    : SFU result stream
// master: stream source (testbench / SFU side); slave: the monitor.
interface sfu_err_monitor_if;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output gold_valid, gold_data, res_valid, res_data,
        input  gold_ready, res_ready
    );

    modport slave (
        input  gold_valid, gold_data, res_valid, res_data,
        output gold_ready, res_ready
    );
endinterface

// File: rtl/sfu_err_monitor.sv
// rtl/sfu_err_monitor.sv - in-order golden/result pairing with ULP error statistics
//
// Purpose: buffers golden words in a FIFO, pairs each SFU result with the FIFO
// head, computes |gold - res| and keeps sample/fail/max/histogram statistics
// over a programmed number of samples.
// Ports:
//   CLK, RST_N          : clock (rising edge), asynchronous active-low reset
//   start               : begin a run (honoured in IDLE or DONE only)
//   sample_total        : samples per run, latched on start
//   precision           : 1 = fp32 compare, 0 = fp16 (low 16 bits), latched on start
//   bus (slave)         : golden and result valid/ready streams
//   err_valid, err_data : one-cycle pulse with the absolute error of the last pair
//   busy, done          : state is RUN / DONE
//   sample_cnt, fail_cnt, max_err : run statistics (counters saturate)
//   hist0, hist1, hist23, hist4p  : error histogram
// Optional feature: define SFU_MON_HIST_EN to build the histogram counters;
// otherwise the hist* ports are tied to zero.
module sfu_err_monitor #(
    parameter int          GOLD_DEPTH = 8,
    parameter int          CNT_W      = 24,
    parameter int unsigned ERR_THRESH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_total,
    input  logic             precision,
    sfu_err_monitor_if.slave bus,
    output logic             err_valid,
    output logic [31:0]      err_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [31:0]      max_err,
    output logic [CNT_W-1:0] hist0,
    output logic [CNT_W-1:0] hist1,
    output logic [CNT_W-1:0] hist23,
    output logic [CNT_W-1:0] hist4p
);
    localparam int         AW      = (GOLD_DEPTH > 1) ? $clog2(GOLD_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(GOLD_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      mem_q [GOLD_DEPTH];
    logic [31:0]      mem_d [GOLD_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] total_q, total_d, sample_cnt_q, sample_cnt_d, fail_cnt_q, fail_cnt_d;
    logic             prec_q, prec_d, err_valid_q, err_valid_d;
    logic [31:0]      err_data_q, err_data_d, max_err_q, max_err_d;

    logic             run, push, pop, start_fire;
    logic [31:0]      gold_op, res_op, diff, err;
    logic [CNT_W-1:0] sample_inc;

    assign run        = (state_q == RUN);
    // Full is taken from registered occupancy, so a pop does not free a slot
    // for a push in the same cycle.
    assign bus.gold_ready = run && (count_q != DEPTH_C);
    assign bus.res_ready  = run && (count_q != '0);
    assign push       = bus.gold_valid && bus.gold_ready;
    assign pop        = bus.res_valid && bus.res_ready;
    assign start_fire = start && !run;

    assign gold_op    = prec_q ? mem_q[rd_ptr_q] : {16'h0, mem_q[rd_ptr_q][15:0]};
    assign res_op     = prec_q ? bus.res_data    : {16'h0, bus.res_data[15:0]};
    assign diff       = gold_op - res_op;
    // Two's-complement magnitude; 0x80000000 maps onto itself.
    assign err        = diff[31] ? (~diff + 32'd1) : diff;
    assign sample_inc = sat_inc(sample_cnt_q);

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        total_d      = total_q;
        prec_d       = prec_q;
        sample_cnt_d = sample_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        err_data_d   = err_data_q;
        max_err_d    = max_err_q;
        err_valid_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = (sample_total == '0) ? DONE : RUN;
                    total_d      = sample_total;
                    prec_d       = precision;
                    sample_cnt_d = '0;
                    fail_cnt_d   = '0;
                    max_err_d    = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    count_d      = '0;
                end
            end
            RUN: begin
                if (push) begin
                    mem_d[wr_ptr_q] = bus.gold_data;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_d     = rd_ptr_q + AW'(1);
                    err_valid_d  = 1'b1;
                    err_data_d   = err;
                    sample_cnt_d = sample_inc;
                    if (err > 32'(ERR_THRESH)) fail_cnt_d = sat_inc(fail_cnt_q);
                    if (err > max_err_q)       max_err_d  = err;
                    if (sample_inc == total_q) state_d    = DONE;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + (AW+1)'(1);
                    2'b01:   count_d = count_q - (AW+1)'(1);
                    default: count_d = count_q;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            for (int i = 0; i < GOLD_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            total_q      <= '0;
            prec_q       <= 1'b0;
            sample_cnt_q <= '0;
            fail_cnt_q   <= '0;
            err_data_q   <= '0;
            max_err_q    <= '0;
            err_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            total_q      <= total_d;
            prec_q       <= prec_d;
            sample_cnt_q <= sample_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            err_data_q   <= err_data_d;
            max_err_q    <= max_err_d;
            err_valid_q  <= err_valid_d;
        end
    end

    assign busy       = run;
    assign done       = (state_q == DONE);
    assign err_valid  = err_valid_q;
    assign err_data   = err_data_q;
    assign sample_cnt = sample_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign max_err    = max_err_q;

`ifdef SFU_MON_HIST_EN
    logic [CNT_W-1:0] h0_q, h0_d, h1_q, h1_d, h23_q, h23_d, h4p_q, h4p_d;

    // start_fire and pop are mutually exclusive (pop only happens in RUN).
    always_comb begin
        h0_d  = h0_q;
        h1_d  = h1_q;
        h23_d = h23_q;
        h4p_d = h4p_q;
        if (start_fire) begin
            h0_d  = '0;
            h1_d  = '0;
            h23_d = '0;
            h4p_d = '0;
        end else if (pop) begin
            if (err == 32'd0)       h0_d  = sat_inc(h0_q);
            else if (err == 32'd1)  h1_d  = sat_inc(h1_q);
            else if (err <= 32'd3)  h23_d = sat_inc(h23_q);
            else                    h4p_d = sat_inc(h4p_q);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h0_q  <= '0;
            h1_q  <= '0;
            h23_q <= '0;
            h4p_q <= '0;
        end else begin
            h0_q  <= h0_d;
            h1_q  <= h1_d;
            h23_q <= h23_d;
            h4p_q <= h4p_d;
        end
    end

    assign hist0  = h0_q;
    assign hist1  = h1_q;
    assign hist23 = h23_q;
    assign hist4p = h4p_q;
`else
    assign hist0  = '0;
    assign hist1  = '0;
    assign hist23 = '0;
    assign hist4p = '0;
`endif
endmodule

// File: tb/tb_sfu_err_monitor.sv
// tb/tb_sfu_err_monitor.sv - directed self-checking bench for sfu_err_monitor
module tb_sfu_err_monitor;
    localparam int CNT_W = 24;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             start;
    logic [CNT_W-1:0] sample_total;
    logic             precision;
    logic             err_valid, busy, done;
    logic [31:0]      err_data, max_err;
    logic [CNT_W-1:0] sample_cnt, fail_cnt, hist0, hist1, hist23, hist4p;

    int n_assert = 0;
    int n_fail   = 0;

    sfu_err_monitor_if bus ();

    sfu_err_monitor #(.GOLD_DEPTH(8), .CNT_W(CNT_W), .ERR_THRESH(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .sample_total(sample_total),
        .precision(precision), .bus(bus), .err_valid(err_valid), .err_data(err_data),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .fail_cnt(fail_cnt),
        .max_err(max_err), .hist0(hist0), .hist1(hist1), .hist23(hist23), .hist4p(hist4p)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [CNT_W-1:0] total, input logic prec);
        start = 1'b1; sample_total = total; precision = prec;
        step();
        start = 1'b0;
    endtask

    task automatic push_gold(input logic [31:0] d);
        int n;
        bus.gold_valid = 1'b1; bus.gold_data = d;
        n = 0;
        while (!bus.gold_ready && n < 20) begin step(); n++; end
        chk("gold_ready_wait", {31'b0, bus.gold_ready}, 32'd1);
        step();
        bus.gold_valid = 1'b0;
    endtask

    task automatic push_res(input logic [31:0] d, input logic [31:0] exp_err);
        int n;
        bus.res_valid = 1'b1; bus.res_data = d;
        n = 0;
        while (!bus.res_ready && n < 20) begin step(); n++; end
        chk("res_ready_wait", {31'b0, bus.res_ready}, 32'd1);
        step();
        bus.res_valid = 1'b0;
        chk("err_valid", {31'b0, err_valid}, 32'd1);
        chk("err_data", err_data, exp_err);
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; sample_total = '0; precision = 1'b1;
        bus.gold_valid = 1'b0; bus.gold_data = '0;
        bus.res_valid = 1'b0;  bus.res_data = '0;
        step(); step();
        chk("rst_gold_ready", {31'b0, bus.gold_ready}, 32'd0);
        chk("rst_res_ready", {31'b0, bus.res_ready}, 32'd0);
        chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err_data", err_data, 32'd0);
        chk("rst_max_err", max_err, 32'd0);
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        RST_N = 1'b1;
        step();

        // fp32 exact
        do_start(4, 1'b1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_gold_ready", {31'b0, bus.gold_ready}, 32'd1);
        chk("t1_res_ready", {31'b0, bus.res_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            push_gold(32'h3F800000);
            push_res(32'h3F800000, 32'd0);
        end
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        chk("t1_sample_cnt", 32'(sample_cnt), 32'd4);
        chk("t1_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("t1_max_err", max_err, 32'd0);
        step();
        chk("t1_err_valid_pulse", {31'b0, err_valid}, 32'd0);

        // sign/abs, threshold, 0x80000000
        do_start(3, 1'b1);
        chk("t2_cleared_cnt", 32'(sample_cnt), 32'd0);
        chk("t2_done_clr", {31'b0, done}, 32'd0);
        push_gold(32'h3F800003); push_res(32'h3F800000, 32'd3);
        push_gold(32'h3F800000); push_res(32'h3F800002, 32'd2);
        chk("t2_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("t2_max_err", max_err, 32'd3);
        push_gold(32'h80000000); push_res(32'h00000000, 32'h80000000);
        chk("t2_fail_cnt_b", 32'(fail_cnt), 32'd2);
        chk("t2_max_err_b", max_err, 32'h80000000);
        chk("t2_done", {31'b0, done}, 32'd1);

        // fp16 masking
        do_start(2, 1'b0);
        push_gold(32'hDEAD3C01); push_res(32'h12343C00, 32'd1);
        push_gold(32'hAAAA0000); push_res(32'h5555FFFF, 32'h0000FFFF);
        chk("t3_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("t3_max_err", max_err, 32'h0000FFFF);

        // backpressure / full
        do_start(9, 1'b1);
        bus.gold_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.gold_data = 32'h100 + 32'(i);
            step();
        end
        chk("t4_full_gold_ready", {31'b0, bus.gold_ready}, 32'd0);
        chk("t4_res_ready", {31'b0, bus.res_ready}, 32'd1);
        bus.gold_data = 32'h108;
        for (int k = 0; k < 9; k++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 32'hFF + 32'(k);
            step();
            if (k == 0) chk("t4_gold_ready_back", {31'b0, bus.gold_ready}, 32'd1);
            if (k == 1) bus.gold_valid = 1'b0;
            chk("t4_err_valid", {31'b0, err_valid}, 32'd1);
            chk("t4_err_data", err_data, 32'd1);
            chk("t4_sample_cnt", 32'(sample_cnt), 32'(k + 1));
        end
        bus.res_valid = 1'b0;
        chk("t4_done", {31'b0, done}, 32'd1);
        chk("t4_gold_ready_done", {31'b0, bus.gold_ready}, 32'd0);
        chk("t4_res_ready_done", {31'b0, bus.res_ready}, 32'd0);
        chk("t4_max_err", max_err, 32'd1);

        // sample_total == 0
        do_start(0, 1'b1);
        chk("t5_done", {31'b0, done}, 32'd1);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_gold_ready", {31'b0, bus.gold_ready}, 32'd0);
        chk("t5_res_ready", {31'b0, bus.res_ready}, 32'd0);

        // start during RUN is ignored
        do_start(2, 1'b1);
        push_gold(32'd5); push_res(32'd5, 32'd0);
        start = 1'b1; sample_total = 5;
        step();
        start = 1'b0;
        chk("t6_busy", {31'b0, busy}, 32'd1);
        chk("t6_sample_cnt", 32'(sample_cnt), 32'd1);
        push_gold(32'd7); push_res(32'd7, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd1);
        chk("t6_sample_cnt_end", 32'(sample_cnt), 32'd2);

        // histogram
        do_start(4, 1'b1);
        push_gold(32'd10); push_res(32'd10, 32'd0);
        push_gold(32'd10); push_res(32'd9,  32'd1);
        push_gold(32'd10); push_res(32'd13, 32'd3);
        push_gold(32'd20); push_res(32'd11, 32'd9);
        chk("t7_fail_cnt", 32'(fail_cnt), 32'd2);
        chk("t7_max_err", max_err, 32'd9);
`ifdef SFU_MON_HIST_EN
        chk("t7_hist0", 32'(hist0), 32'd1);
        chk("t7_hist1", 32'(hist1), 32'd1);
        chk("t7_hist23", 32'(hist23), 32'd1);
        chk("t7_hist4p", 32'(hist4p), 32'd1);
`else
        chk("t7_hist0", 32'(hist0), 32'd0);
        chk("t7_hist1", 32'(hist1), 32'd0);
        chk("t7_hist23", 32'(hist23), 32'd0);
        chk("t7_hist4p", 32'(hist4p), 32'd0);
`endif

        // asynchronous reset mid-run
        do_start(3, 1'b1);
        push_gold(32'd4); push_res(32'd1, 32'd3);
        push_gold(32'd4);
        RST_N = 1'b0;
        #2;
        chk("t8_busy", {31'b0, busy}, 32'd0);
        chk("t8_gold_ready", {31'b0, bus.gold_ready}, 32'd0);
        chk("t8_res_ready", {31'b0, bus.res_ready}, 32'd0);
        chk("t8_err_data", err_data, 32'd0);
        chk("t8_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("t8_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("t8_max_err", max_err, 32'd0);
        RST_N = 1'b1;
        step();
        chk("t8_done", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sfu_err_monitor.md
# sfu_err_monitor

Synthesizable result checker at the output end of the SFU stimulus path: it accepts golden values and SFU results over two valid/ready streams and pairs them in order. For each pair it computes the absolute integer difference (ULP distance) and keeps pass/fail statistics over a programmed sample count. It is the on-chip counterpart of the bench-side error dump, used behind `SFU_top` in FPGA/emulation bring-up.

## Interface
- `GOLD_DEPTH`, 8, golden FIFO depth (power of two, ≥2)
- `CNT_W`, 24, width of sample/fail counters
- `ERR_THRESH`, 2, error magnitude above which a sample counts as fail
- `CLK` in 1 — single clock, rising edge
- `RST_N` in 1 — reset, asynchronous, active-low
- `start` in 1 — begin a run; sampled only in IDLE or DONE
- `sample_total` in CNT_W — samples in the run, latched on `start`
- `precision` in 1 — 1: fp32 (32-bit compare), 0: fp16 (low 16 bits, zero-extended); latched on `start`
- `gold_valid` in 1 / `gold_ready` out 1 / `gold_data` in 32 — golden stream
- `res_valid` in 1 / `res_ready` out 1 / `res_data` in 32 — SFU result stream
- `err_valid` out 1 — one-cycle pulse, `err_data` valid
- `err_data` out 32 — absolute error of the last pair
- `busy` out 1 — state is RUN
- `done` out 1 — state is DONE
- `sample_cnt` out CNT_W — pairs checked
- `fail_cnt` out CNT_W — pairs with error > ERR_THRESH
- `max_err` out 32 — largest error seen in the run
- `hist0`, `hist1`, `hist23`, `hist4p` out CNT_W each — error histogram (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + `start`: clear counters, `max_err`, histogram, and FIFO; latch `sample_total`, `precision`. Go to RUN, or straight to DONE if `sample_total`==0. `start` in RUN is ignored.
- Golden FIFO: `gold_ready` = RUN && !full. Push on `gold_valid && gold_ready`. No bypass; golden data must arrive at least one cycle before its result.
- `res_ready` = RUN && FIFO not empty. On a result fire, pop the FIFO head and pair it with `res_data`.
- Pair arithmetic:
  - fp32: diff = gold − res, mod 2^32.
  - fp16: diff = {16'b0, gold[15:0]} − {16'b0, res[15:0]}, mod 2^32.
  - err = diff[31] ? (~diff + 1) : diff. 0x80000000 stays 0x80000000.
- Registered update per pair:
  - `err_data` ← err.
  - `sample_cnt` +1.
  - `fail_cnt` +1 if err > ERR_THRESH (unsigned).
  - `max_err` ← max(`max_err`, err).
- Counters saturate at all-ones.
- When the pair that makes `sample_cnt` equal `sample_total` is registered, go to DONE. DONE holds all statistics and deasserts both readies.
- Push and pop in the same cycle are legal at any occupancy, including full (pop frees a slot; the full flag is computed from registered occupancy, so the push is still refused that cycle). Leftover FIFO entries at DONE are discarded on the next `start`.

## Timing
- Reset values: `gold_ready`, `res_ready`, `err_valid`, `busy`, `done` = 0; `err_data`, `max_err`, all counters and histogram = 0; FIFO empty.
- Reset mid-run: immediate return to reset values; the run is lost.
- `start` at edge t: `busy` = 1 from t+1 and `gold_ready` = 1 from t+1. `res_ready` rises no earlier than t+2, the cycle after the first golden push.
- Result fire at edge t: at t+1, `err_valid` = 1 and `err_data`, counters, `max_err` are all updated together.
- Final pair fired at t: at t+1, `done` = 1 and `busy` = 0, in the same cycle as the last `err_valid`.
- Throughput: one pair per cycle when both streams are continuous.

## Configuration
- `SFU_MON_HIST_EN` defined: histogram counters update per pair. Buckets: `hist0` err==0, `hist1` err==1, `hist23` err in 2..3, `hist4p` err≥4. Counters saturate and clear on `start`.
- Not defined: no histogram registers are built; the four `hist*` ports are tied to 0. The port list is unchanged.

## Test plan
- **fp32 exact:** `sample_total`=4, golden = results = 0x3F800000 ×4 → four `err_valid` pulses with `err_data`=0; final `sample_cnt`=4, `fail_cnt`=0, `max_err`=0, `done`=1.
- **Sign/abs and threshold:**
  - gold 0x3F800003 / res 0x3F800000 → err=3, fail.
  - gold 0x3F800000 / res 0x3F800002 → err=2, pass.
  - Expect `fail_cnt`=1, `max_err`=3.
- **fp16 masking:** `precision`=0, gold 0xDEAD3C01 / res 0x12343C00 → `err_data`=1.
- **Backpressure/full:** push 8 golden words with `res_valid`=0 → `gold_ready` falls after the 8th push. Then present results continuously → one pair per cycle; `gold_ready` returns the cycle after the first pop.
- **Edge cases:**
  - `sample_total`=0 → `done` at t+1 with no readies asserted.
  - `start` during RUN → ignored.
  - `RST_N` low mid-run → all outputs 0 asynchronously.
- **Histogram:** errors 0, 1, 3, 9 → with `SFU_MON_HIST_EN`: `hist0`=`hist1`=`hist23`=`hist4p`=1. Without it: all four are 0.
